// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux2_arb_pkg;

  // Arbitration state: who currently owns the shared mux.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Mux select encodings.
  localparam logic SEL_D0 = 1'b0;
  localparam logic SEL_D1 = 1'b1;

endpackage

// File: rtl/mux2_arbiter_mux.sv
// Single-bit 2-to-1 multiplexer; one instance per datapath bit.
module twoToOneMux (
  input  logic d0_i,
  input  logic d1_i,
  input  logic sel_i,
  output logic y_o
);

  // Pure combinational select; the result is registered by the parent.
  always_comb begin
    y_o = sel_i ? d1_i : d0_i;
  end

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter owning a shared 2-to-1 mux, with a bounded hold time
// under contention and a registered, valid-qualified mux output.
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [DATA_W-1:0] d0_i,
  input  logic [DATA_W-1:0] d1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              sel_o,
  output logic [DATA_W-1:0] y_o,
  output logic              y_valid_o
);

  // Hold counter only needs to reach MAX_HOLD-1; keep at least one bit.
  localparam int unsigned CntW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CntW-1:0] CntMax = (MAX_HOLD == 0) ? '0 : CntW'(MAX_HOLD - 1);

  arb_state_e        state_q, state_d;
  logic              sel_q, sel_d;
  logic              last_owner_q, last_owner_d;
  logic [CntW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic              y_valid_q, y_valid_d;
  logic [DATA_W-1:0] mux_y;
  logic              limit_hit;
  logic [CntW-1:0]   hold_cnt_inc;

  assign limit_hit    = (MAX_HOLD != 0) && (hold_cnt_q == CntMax);
  // Saturating increment used while an owner keeps the grant.
  assign hold_cnt_inc = ((MAX_HOLD != 0) && (hold_cnt_q != CntMax)) ?
                        hold_cnt_q + CntW'(1) : hold_cnt_q;

  // Next-state arbitration: round-robin ties, direct handover, forced handover.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (req0_i && (!req1_i || last_owner_q)) begin
          state_d      = OWN0;
          sel_d        = SEL_D0;
          last_owner_d = 1'b0;
          hold_cnt_d   = '0;
        end else if (req1_i) begin
          state_d      = OWN1;
          sel_d        = SEL_D1;
          last_owner_d = 1'b1;
          hold_cnt_d   = '0;
        end
      end
      OWN0: begin
        if (req1_i && (!req0_i || limit_hit)) begin
          state_d      = OWN1;
          sel_d        = SEL_D1;
          last_owner_d = 1'b1;
          hold_cnt_d   = '0;
        end else if (!req0_i) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_inc;
        end
      end
      OWN1: begin
        if (req0_i && (!req1_i || limit_hit)) begin
          state_d      = OWN0;
          sel_d        = SEL_D0;
          last_owner_d = 1'b0;
          hold_cnt_d   = '0;
        end else if (!req1_i) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One mux per data bit, steered by the registered select.
  for (genvar i = 0; i < int'(DATA_W); i++) begin : g_mux
    twoToOneMux u_mux (
      .d0_i  (d0_i[i]),
      .d1_i  (d1_i[i]),
      .sel_i (sel_q),
      .y_o   (mux_y[i])
    );
  end

  // Output register loads only while someone owns the mux; valid tracks owner req.
  always_comb begin
    y_d       = (state_q != IDLE) ? mux_y : y_q;
    y_valid_d = ((state_q == OWN0) && req0_i) || ((state_q == OWN1) && req1_i);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= SEL_D0;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= '0;
      y_q          <= '0;
      y_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
      y_q          <= y_d;
      y_valid_q    <= y_valid_d;
    end
  end

  assign gnt0_o    = (state_q == OWN0);
  assign gnt1_o    = (state_q == OWN1);
  assign sel_o     = sel_q;
  assign y_o       = y_q;
  assign y_valid_o = y_valid_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: stimulus pushes predicted outputs, a
// monitor pops and compares after every rising edge.
module tb_mux2_arbiter;

  localparam int DW = 1;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic          gnt0, gnt1, sel, y_valid;
  logic [DW-1:0] y;

  int checks = 0;
  int errors = 0;

  // Expected {gnt0, gnt1, sel, y, y_valid} after the next rising edge.
  logic [DW+3:0] exp_q[$];

  // Reference model: owner (-1 none), previous owner, cycles held so far.
  int            m_owner = -1;
  int            m_last  = 1;
  int            m_ten   = 0;
  logic          m_sel   = 1'b0;
  logic [DW-1:0] m_y     = '0;
  logic          m_yv    = 1'b0;

  mux2_arbiter #(
    .DATA_W   (DW),
    .MAX_HOLD (MH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_i    (req0),
    .req1_i    (req1),
    .d0_i      (d0),
    .d1_i      (d1),
    .gnt0_o    (gnt0),
    .gnt1_o    (gnt1),
    .sel_o     (sel),
    .y_o       (y),
    .y_valid_o (y_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_ten   = 0;
    m_sel   = 1'b0;
    m_y     = '0;
    m_yv    = 1'b0;
  endtask

  // Drive inputs for the coming edge and predict the outputs after it.
  task automatic apply(input logic r0, input logic r1, input logic [DW-1:0] a0,
                       input logic [DW-1:0] a1);
    int nxt;
    bit rq[2];
    req0 = r0; req1 = r1; d0 = a0; d1 = a1;
    rq[0] = r0; rq[1] = r1;
    // Owner's data is captured, valid only while the owner still requests.
    if (m_owner == 0) begin
      m_y = a0; m_yv = r0;
    end else if (m_owner == 1) begin
      m_y = a1; m_yv = r1;
    end else begin
      m_yv = 1'b0;
    end
    if (m_owner < 0) begin
      if (r0 && r1)  nxt = 1 - m_last;
      else if (r0)   nxt = 0;
      else if (r1)   nxt = 1;
      else           nxt = -1;
    end else if (!rq[m_owner]) begin
      nxt = rq[1 - m_owner] ? 1 - m_owner : -1;
    end else if (rq[1 - m_owner] && MH > 0 && m_ten >= MH) begin
      nxt = 1 - m_owner;
    end else begin
      nxt = m_owner;
    end
    if (nxt < 0) begin
      m_owner = -1;
    end else if (nxt != m_owner) begin
      m_owner = nxt;
      m_last  = nxt;
      m_sel   = (nxt == 1);
      m_ten   = 1;
    end else begin
      m_ten++;
    end
    exp_q.push_back({m_owner == 0, m_owner == 1, m_sel, m_y, m_yv});
  endtask

  task automatic drive(input logic r0, input logic r1, input logic [DW-1:0] a0,
                       input logic [DW-1:0] a1);
    @(negedge clk);
    apply(r0, r1, a0, a1);
  endtask

  // Assert reset mid-cycle, check the asynchronous clear, release at a negedge.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; d0 = '0; d1 = '0;
    model_reset();
    #1;
    check("async_reset_clear", {gnt0, gnt1, sel, y, y_valid}, '0);
    exp_q.push_back('0);
    repeat (cycles - 1) begin
      @(negedge clk);
      exp_q.push_back('0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 1'b0, '0, '0);
  endtask

  // Monitor: compare the DUT against the oldest prediction after each edge.
  initial begin
    logic [DW+3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs{gnt0,gnt1,sel,y,y_valid}", {gnt0, gnt1, sel, y, y_valid}, e);
        if (gnt0 && gnt1) check("gnt_exclusive", {gnt0, gnt1}, 2'b00);
      end
    end
  end

  initial begin
    logic r0, r1;
    // Power-on reset, then idle.
    model_reset();
    repeat (2) begin
      @(negedge clk);
      exp_q.push_back('0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 1'b0, '0, '0);
    repeat (5) drive(1'b0, 1'b0, '0, '0);

    // Mid-cycle asynchronous reset from idle.
    do_reset(2);

    // Single requester 1.
    repeat (3) drive(1'b0, 1'b1, '0, 1'b1);
    repeat (3) drive(1'b0, 1'b0, '0, '0);

    // Tie after reset goes to req0, direct handover, later tie from idle.
    do_reset(2);
    repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0, '0, '0);
    repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0, '0, '0);

    // Starvation limit: req0 continuous, req1 joins a cycle after the grant.
    do_reset(2);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (14) drive(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b0, '0, '0);

    // Datapath truth table through single-requester ownership.
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 2; a++) begin
        for (int b = 0; b < 2; b++) begin
          repeat (3) drive(s == 0, s == 1, DW'(a), DW'(b));
          drive(1'b0, 1'b0, '0, '0);
        end
      end
    end

    // Reset while req1 owns and req0 waits; req0 wins the tie afterwards.
    repeat (2) drive(1'b0, 1'b1, '0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    do_reset(2);
    repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, '0);

    // Randomized sticky requests with occasional resets.
    r0 = 1'b0;
    r1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset(1 + $urandom_range(2));
        r0 = 1'b0;
        r1 = 1'b0;
      end else begin
        if ($urandom_range(3) == 0) r0 = ~r0;
        if ($urandom_range(3) == 0) r1 = ~r1;
        drive(r0, r1, DW'($urandom), DW'($urandom));
      end
    end
    repeat (3) drive(1'b0, 1'b0, '0, '0);

    // Drain the scoreboard within a bounded number of edges.
    repeat (4) @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
